// File: rtl/decode_exec_fsm_if.sv
// Fetch-to-execute handshake plus memory bus and PC-redirect signals of the execute stage.
// master is the execute stage; slave is the fetch/memory side.
interface decode_exec_fsm_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              ir_load;
    logic [15:0]       ir_in;
    logic              MFC;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_EN;
    logic              mem_RW;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              done;
    logic              halted;
    logic              zero_flag;

    modport master (
        input  ir_load, ir_in, MFC, mem_rdata,
        output mem_EN, mem_RW, mem_addr, mem_wdata, pc_load, pc_target, done, halted, zero_flag
    );

    modport slave (
        output ir_load, ir_in, MFC, mem_rdata,
        input  mem_EN, mem_RW, mem_addr, mem_wdata, pc_load, pc_target, done, halted, zero_flag
    );
endinterface

// File: rtl/decode_exec_fsm.sv
// Execute stage: captures an instruction from fetch, runs it against a 4-entry register file,
// handles LD/ST over an MFC handshake and reports completion with a one-cycle done pulse.
module decode_exec_fsm #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input logic               clk,
    input logic               rst,
    decode_exec_fsm_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StDone,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpLdi  = 4'h1,
        OpAdd  = 4'h2,
        OpSub  = 4'h3,
        OpAnd  = 4'h4,
        OpOr   = 4'h5,
        OpLd   = 4'h6,
        OpSt   = 4'h7,
        OpJmp  = 4'h8,
        OpBrz  = 4'h9,
        OpHalt = 4'hF
    } opcode_e;

    state_e            state_q, state_d;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] opa_q, opb_q;
    logic              z_q;

    opcode_e           opcode;
    logic [1:0]        rd, rs;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] imm_ext;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wd;
    logic              mem_en, mem_rw, pc_load, done, halted;
    logic [ADDR_W-1:0] mem_addr, pc_target;
    logic [DATA_W-1:0] mem_wdata;

    assign opcode  = opcode_e'(ir_q[15:12]);
    assign rd      = ir_q[11:10];
    assign rs      = ir_q[9:8];
    assign imm     = ir_q[ADDR_W-1:0];
    assign imm_ext = {{(DATA_W - ADDR_W){1'b0}}, imm};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
            z_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (state_q == StIdle && bus.ir_load) begin
                ir_q <= bus.ir_in;
            end
            if (state_q == StDecode) begin
                opa_q <= rf_q[rd];
                opb_q <= rf_q[rs];
            end
            // Every register write also refreshes Z from the written value.
            if (rf_we) begin
                rf_q[rd] <= rf_wd;
                z_q      <= (rf_wd == '0);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rf_we     = 1'b0;
        rf_wd     = '0;
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_load   = 1'b0;
        pc_target = '0;
        done      = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.ir_load) state_d = StDecode;
            end
            StDecode: state_d = StExec;
            StExec: begin
                state_d = StDone;
                unique case (opcode)
                    OpLdi: begin rf_we = 1'b1; rf_wd = imm_ext;         end
                    OpAdd: begin rf_we = 1'b1; rf_wd = opa_q + opb_q;   end
                    OpSub: begin rf_we = 1'b1; rf_wd = opa_q - opb_q;   end
                    OpAnd: begin rf_we = 1'b1; rf_wd = opa_q & opb_q;   end
                    OpOr:  begin rf_we = 1'b1; rf_wd = opa_q | opb_q;   end
                    OpLd, OpSt: state_d = StMem;
                    OpJmp: begin pc_load = 1'b1; pc_target = imm;       end
                    OpBrz: begin
                        if (z_q) begin
                            pc_load   = 1'b1;
                            pc_target = imm;
                        end
                    end
                    OpHalt: state_d = StHalt;
                    default: ;  // NOP and the illegal opcodes A-E
                endcase
            end
            StMem: begin
                // Held stable every cycle until MFC is seen on a rising edge.
                mem_en   = 1'b1;
                mem_rw   = (opcode == OpLd);
                mem_addr = imm;
                if (opcode == OpSt) mem_wdata = opa_q;
                if (bus.MFC) begin
                    state_d = StDone;
                    if (opcode == OpLd) begin
                        rf_we = 1'b1;
                        rf_wd = bus.mem_rdata;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StHalt: halted = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_EN    = mem_en;
    assign bus.mem_RW    = mem_rw;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.pc_load   = pc_load;
    assign bus.pc_target = pc_target;
    assign bus.done      = done;
    assign bus.halted    = halted;
    assign bus.zero_flag = z_q;

endmodule

// File: tb/tb_decode_exec_fsm.sv
// Bench for decode_exec_fsm: directed vector table, randomized instructions against an
// architectural model, and hand-written HALT and mid-transfer reset sequences.
module tb_decode_exec_fsm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decode_exec_fsm_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    decode_exec_fsm #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] ins;
        int          wait_n;
        logic [15:0] rdata;
        int          lat;    // negedge index of the done cycle, first index is the DECODE cycle
        logic        pc;
        logic [7:0]  tgt;
        logic        mem;
        logic        rw;
        logic [15:0] wdata;
        logic        z;
    } vec_t;

    // Architectural state: four registers and Z.
    logic [15:0] m_r [4];
    logic        m_z;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
        m_z = 1'b0;
    endtask

    task automatic predict(input logic [15:0] ins, input int wait_n, input logic [15:0] rdata,
                           output vec_t v);
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [15:0] res;
        logic        wr;
        op = ins[15:12];
        rd = ins[11:10];
        rs = ins[9:8];
        wr = 1'b1;
        res = 16'h0;
        v = '{ins, wait_n, rdata, 3, 1'b0, ins[7:0], 1'b0, 1'b0, 16'h0, 1'b0};
        case (op)
            4'h1: res = {8'h00, ins[7:0]};
            4'h2: res = m_r[rd] + m_r[rs];
            4'h3: res = m_r[rd] - m_r[rs];
            4'h4: res = m_r[rd] & m_r[rs];
            4'h5: res = m_r[rd] | m_r[rs];
            4'h6: begin res = rdata; v.mem = 1'b1; v.rw = 1'b1; v.lat = 3 + wait_n; end
            4'h7: begin wr = 1'b0; v.mem = 1'b1; v.wdata = m_r[rd]; v.lat = 3 + wait_n; end
            4'h8: begin wr = 1'b0; v.pc = 1'b1; end
            4'h9: begin wr = 1'b0; v.pc = m_z; end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_r[rd] = res;
            m_z     = (res == 16'h0);
        end
        v.z = m_z;
    endtask

    // Issue one instruction and observe it until done, checking everything on the way.
    task automatic run(input vec_t v, input string tag);
        int       cyc, done_cyc, mem_cyc, bad, pc_cnt;
        logic [7:0] tgt;
        logic     last_z;
        done_cyc = 0; mem_cyc = 0; bad = 0; pc_cnt = 0; tgt = 8'h00; last_z = 1'bx;
        @(negedge clk);
        bus.ir_load = 1'b1; bus.ir_in = v.ins; bus.mem_rdata = v.rdata; bus.MFC = 1'b0;
        @(negedge clk);
        bus.ir_load = 1'b0;
        cyc = 1;
        while (cyc <= 40 && done_cyc == 0) begin
            if (bus.done) begin
                done_cyc = cyc;
                last_z   = bus.zero_flag;
            end else begin
                if (bus.pc_load) begin pc_cnt++; tgt = bus.pc_target; end
                if (bus.mem_EN) begin
                    mem_cyc++;
                    if (bus.mem_RW !== v.rw || bus.mem_addr !== v.ins[7:0] ||
                        (!v.rw && bus.mem_wdata !== v.wdata)) bad++;
                    bus.MFC = (mem_cyc == v.wait_n);
                end else begin
                    bus.MFC = 1'($urandom_range(0, 1));  // must be ignored outside MEM
                end
                bus.ir_load = 1'($urandom_range(0, 1));  // must be ignored while busy
                bus.ir_in   = 16'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        bus.ir_load = 1'b0;
        bus.MFC     = 1'b0;
        check({tag, ".latency"}, 32'(done_cyc), 32'(v.lat));
        check({tag, ".pc_load_cnt"}, 32'(pc_cnt), 32'(v.pc));
        if (v.pc) check({tag, ".pc_target"}, 32'(tgt), 32'(v.tgt));
        check({tag, ".mem_cycles"}, 32'(mem_cyc), v.mem ? 32'(v.wait_n) : 32'd0);
        if (v.mem) check({tag, ".mem_bus_held"}, 32'(bad), 32'd0);
        check({tag, ".zero_flag"}, 32'(last_z), 32'(v.z));
        @(negedge clk);
        check({tag, ".done_width"}, 32'(bus.done), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.ir_load = 1'b0; bus.ir_in = 16'h0; bus.MFC = 1'b0; bus.mem_rdata = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".mem_EN"},    32'(bus.mem_EN), 32'd0);
        check({tag, ".mem_RW"},    32'(bus.mem_RW), 32'd0);
        check({tag, ".mem_addr"},  32'(bus.mem_addr), 32'd0);
        check({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, ".pc_load"},   32'(bus.pc_load), 32'd0);
        check({tag, ".pc_target"}, 32'(bus.pc_target), 32'd0);
        check({tag, ".done"},      32'(bus.done), 32'd0);
        check({tag, ".halted"},    32'(bus.halted), 32'd0);
        check({tag, ".zero_flag"}, 32'(bus.zero_flag), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        vec_t v, dummy;
        int   cnt;

        // {ins, wait_n, rdata, lat, pc, tgt, mem, rw, wdata, z}
        tbl.push_back('{16'h1405, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h2500, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h7420, 4, 16'h0000, 7, 1'b0, 8'h00, 1'b1, 1'b0, 16'h000A, 1'b0});
        tbl.push_back('{16'h1800, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h3A00, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h1C01, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h1800, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h3B00, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h7800, 1, 16'h0000, 4, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF, 1'b0});
        tbl.push_back('{16'h6C20, 2, 16'h1234, 5, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b0});
        tbl.push_back('{16'h7C55, 1, 16'h0000, 4, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0});
        tbl.push_back('{16'h8040, 0, 16'h0000, 3, 1'b1, 8'h40, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h9010, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h4E00, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h1000, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h9033, 0, 16'h0000, 3, 1'b1, 8'h33, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'hA123, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h5100, 0, 16'h0000, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
        tbl.push_back('{16'h7012, 3, 16'h0000, 6, 1'b0, 8'h00, 1'b1, 1'b0, 16'h000A, 1'b0});
        tbl.push_back('{16'h6000, 1, 16'h0000, 4, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b1});

        bus.ir_load = 1'b0; bus.ir_in = 16'h0; bus.MFC = 1'b0; bus.mem_rdata = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;

        // Directed table; the model follows along so the random phase continues from it.
        foreach (tbl[i]) begin
            predict(tbl[i].ins, tbl[i].wait_n, tbl[i].rdata, dummy);
            run(tbl[i], $sformatf("tbl%0d", i));
        end

        // Random instructions (HALT excluded) against the model.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [15:0] ins, rdata;
            int          w;
            op    = 4'($urandom_range(0, 14));
            ins   = {op, 12'($urandom)};
            if (op == 4'h1 && $urandom_range(0, 3) == 0) ins[7:0] = 8'h00;
            rdata = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            w     = $urandom_range(1, 5);
            predict(ins, w, rdata, v);
            run(v, $sformatf("rnd%0d_%04h", i, ins));
        end

        // HALT: halted rises, done never comes, later ir_load ignored.
        @(negedge clk);
        bus.ir_load = 1'b1; bus.ir_in = 16'hF000;
        @(negedge clk);
        bus.ir_load = 1'b0;
        cnt = 0;
        repeat (8) begin
            if (bus.done) cnt++;
            @(negedge clk);
        end
        check("halt.halted", 32'(bus.halted), 32'd1);
        check("halt.no_done", 32'(cnt), 32'd0);
        bus.ir_load = 1'b1; bus.ir_in = 16'h1405;
        @(negedge clk);
        bus.ir_load = 1'b0;
        cnt = 0;
        repeat (6) begin
            if (bus.done || bus.mem_EN) cnt++;
            @(negedge clk);
        end
        check("halt.ir_load_ignored", 32'(cnt), 32'd0);
        check("halt.still_halted", 32'(bus.halted), 32'd1);

        // Reset during the MEM phase of a LD drops mem_EN without a clock edge.
        do_reset();
        check("rst.halt_cleared", 32'(bus.halted), 32'd0);
        predict(16'h1477, 0, 16'h0, v);
        run(v, "rst.ldi");
        @(negedge clk);
        bus.ir_load = 1'b1; bus.ir_in = 16'h6430; bus.mem_rdata = 16'hBEEF;
        @(negedge clk);
        bus.ir_load = 1'b0;
        cnt = 0;
        while (!bus.mem_EN && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("rst.mem_reached", 32'(bus.mem_EN), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("rst.async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] ri;
            ri = 2'(r);
            predict({4'h7, ri, 2'b00, 8'h00}, 1, 16'h0, v);
            run(v, $sformatf("rst.st_r%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
